// File: rtl/ob_cmd_sched.sv
// Order-book command scheduler: ingress FIFO feeding a one-in-flight issue/response FSM.
// Optional issue watchdog enabled by defining OB_CMD_TIMEOUT_EN.
module ob_cmd_sched #(
  parameter int unsigned CMD_W       = 64,
  parameter int unsigned FIFO_N      = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ingress_vld,
  input  logic [CMD_W-1:0]             ingress_cmd,
  output logic                         ingress_consume,
  output logic                         eng_req,
  output logic [CMD_W-1:0]             eng_cmd,
  input  logic                         eng_ack,
  input  logic                         eng_err,
  output logic                         egress_vld,
  output logic [1:0]                   egress_status,
  input  logic                         egress_rdy,
  output logic [$clog2(FIFO_N+1)-1:0]  fifo_cnt,
  output logic                         busy
);

  localparam int unsigned CntW = $clog2(FIFO_N + 1);
  localparam int unsigned PtrW = $clog2(FIFO_N);

  localparam logic [1:0] StatOk  = 2'b00;
  localparam logic [1:0] StatErr = 2'b01;
`ifdef OB_CMD_TIMEOUT_EN
  localparam logic [1:0] StatTmo = 2'b10;
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StResp  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [1:0]        status_q, status_d;
  logic              eng_req_q, eng_req_d;
  logic              egress_vld_q, egress_vld_d;
  logic [CMD_W-1:0]  mem_q [FIFO_N];

  logic not_full;
  logic push;
  logic pop;

  // Space is judged from the registered count only, so a same-cycle pop never frees a slot.
  assign not_full = (cnt_q != CntW'(FIFO_N));
  assign push     = ingress_vld & not_full;
  assign pop      = (state_q == StIdle) && (cnt_q != '0);

`ifdef OB_CMD_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_hit;

  // Fires on the cycle whose missing ack would bring the count to TIMEOUT_CYC.
  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (pop) begin
      tmo_d = '0;
    end else if (state_q == StIssue && !eng_ack) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    status_d     = status_q;
    eng_req_d    = eng_req_q;
    egress_vld_d = egress_vld_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          cmd_d     = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + PtrW'(1);
          eng_req_d = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (eng_ack) begin
          status_d     = eng_err ? StatErr : StatOk;
          eng_req_d    = 1'b0;
          egress_vld_d = 1'b1;
          state_d      = StResp;
        end
`ifdef OB_CMD_TIMEOUT_EN
        else if (tmo_hit) begin
          status_d     = StatTmo;
          eng_req_d    = 1'b0;
          egress_vld_d = 1'b1;
          state_d      = StResp;
        end
`endif
      end
      StResp: begin
        if (egress_rdy) begin
          egress_vld_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: begin
        eng_req_d    = 1'b0;
        egress_vld_d = 1'b0;
        state_d      = StIdle;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      cmd_q        <= '0;
      status_q     <= StatOk;
      eng_req_q    <= 1'b0;
      egress_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      status_q     <= status_d;
      eng_req_q    <= eng_req_d;
      egress_vld_q <= egress_vld_d;
    end
  end

  // Storage needs no reset: only slots below the count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ingress_cmd;
    end
  end

  assign ingress_consume = rst_n & not_full;
  assign eng_req         = eng_req_q;
  assign eng_cmd         = cmd_q;
  assign egress_vld      = egress_vld_q;
  assign egress_status   = status_q;
  assign fifo_cnt        = cnt_q;
  assign busy            = (state_q != StIdle) || (cnt_q != '0);

endmodule

// File: tb/tb_ob_cmd_sched.sv
// Randomised and directed bench for ob_cmd_sched against a queue-based transaction model.
// Honours OB_CMD_TIMEOUT_EN when defined for the build.
module tb_ob_cmd_sched;

  localparam int unsigned CMD_W       = 64;
  localparam int unsigned FIFO_N      = 4;
  localparam int unsigned TIMEOUT_CYC = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ingress_vld = 1'b0;
  logic [CMD_W-1:0]  ingress_cmd = '0;
  logic              ingress_consume;
  logic              eng_req;
  logic [CMD_W-1:0]  eng_cmd;
  logic              eng_ack = 1'b0;
  logic              eng_err = 1'b0;
  logic              egress_vld;
  logic [1:0]        egress_status;
  logic              egress_rdy = 1'b0;
  logic [2:0]        fifo_cnt;
  logic              busy;

  ob_cmd_sched #(
    .CMD_W      (CMD_W),
    .FIFO_N     (FIFO_N),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ingress_vld    (ingress_vld),
    .ingress_cmd    (ingress_cmd),
    .ingress_consume(ingress_consume),
    .eng_req        (eng_req),
    .eng_cmd        (eng_cmd),
    .eng_ack        (eng_ack),
    .eng_err        (eng_err),
    .egress_vld     (egress_vld),
    .egress_status  (egress_status),
    .egress_rdy     (egress_rdy),
    .fifo_cnt       (fifo_cnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: 0 = waiting, 1 = command with engine, 2 = status pending.
  int               ph = 0;
  logic [CMD_W-1:0] q[$];
  logic [CMD_W-1:0] cur = '0;
  logic [1:0]       stat = 2'b00;
  int               tcnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit room;
    bit take;
    room = (q.size() != FIFO_N);
    take = ingress_vld && room;
    case (ph)
      0: if (q.size() != 0) begin
        cur  = q.pop_front();
        ph   = 1;
        tcnt = 0;
      end
      1: begin
        if (eng_ack) begin
          stat = eng_err ? 2'b01 : 2'b00;
          ph   = 2;
        end
`ifdef OB_CMD_TIMEOUT_EN
        else begin
          tcnt++;
          if (tcnt == TIMEOUT_CYC) begin
            stat = 2'b10;
            ph   = 2;
          end
        end
`endif
      end
      default: if (egress_rdy) ph = 0;
    endcase
    if (take) q.push_back(ingress_cmd);
  endtask

  task automatic compare();
    chk("eng_req", 64'(eng_req), 64'(ph == 1));
    if (ph == 1) chk("eng_cmd", eng_cmd, cur);
    chk("egress_vld", 64'(egress_vld), 64'(ph == 2));
    if (ph == 2) chk("egress_status", 64'(egress_status), 64'(stat));
    chk("fifo_cnt", 64'(fifo_cnt), 64'(q.size()));
    chk("ingress_consume", 64'(ingress_consume), 64'(q.size() != FIFO_N));
    chk("busy", 64'(busy), 64'(ph != 0 || q.size() != 0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_eng_req", 64'(eng_req), 64'd0);
    chk("rst_egress_vld", 64'(egress_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_consume", 64'(ingress_consume), 64'd0);
    chk("rst_status", 64'(egress_status), 64'd0);
    chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    ph = 0;
    q.delete();
    cur  = '0;
    stat = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rel_consume", 64'(ingress_consume), 64'd1);
    chk("rel_fifo_cnt", 64'(fifo_cnt), 64'd0);
  endtask

  task automatic idle_inputs();
    ingress_vld = 1'b0;
    eng_ack     = 1'b0;
    eng_err     = 1'b0;
    egress_rdy  = 1'b0;
  endtask

  initial begin
    int req_cyc;
    int vld_cyc;
    int pushed;

    do_reset();

    // Single command, ack on the third issue cycle.
    ingress_vld = 1'b1;
    ingress_cmd = 64'hA5;
    step();
    ingress_vld = 1'b0;
    req_cyc = 0;
    vld_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (eng_req) req_cyc++;
    end
    chk("single_cmd", eng_cmd, 64'hA5);
    eng_ack    = 1'b1;
    egress_rdy = 1'b1;
    step();
    if (egress_vld) vld_cyc++;
    chk("single_status", 64'(egress_status), 64'd0);
    eng_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (eng_req) req_cyc++;
      if (egress_vld) vld_cyc++;
    end
    chk("single_req_cycles", 64'(req_cyc), 64'd3);
    chk("single_vld_cycles", 64'(vld_cyc), 64'd1);

    // Five pushes with the engine stalled, then drain in order.
    idle_inputs();
    pushed = 0;
    for (int i = 0; i < 20 && pushed < 5; i++) begin
      bit acc;
      ingress_vld = 1'b1;
      ingress_cmd = 64'(pushed + 1);
      acc = ingress_consume;
      step();
      if (acc) pushed++;
    end
    chk("fill_pushed", 64'(pushed), 64'd5);
    ingress_vld = 1'b0;
    chk("fill_full", 64'(fifo_cnt), 64'(FIFO_N));
    chk("fill_consume", 64'(ingress_consume), 64'd0);
    repeat (4) step();
    eng_ack    = 1'b1;
    egress_rdy = 1'b1;
    for (int i = 0; i < 30 && busy; i++) step();
    chk("drain_idle", 64'(busy), 64'd0);

    // Error status held while the consumer stalls.
    idle_inputs();
    ingress_vld = 1'b1;
    ingress_cmd = 64'h1111;
    step();
    ingress_cmd = 64'h2222;
    step();
    ingress_vld = 1'b0;
    eng_ack = 1'b1;
    eng_err = 1'b1;
    step();
    eng_ack = 1'b0;
    eng_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("err_held", 64'(egress_status), 64'd1);
    end
    egress_rdy = 1'b1;
    step();
    egress_rdy = 1'b0;
    step();
    chk("err_next_cmd", eng_cmd, 64'h2222);
    eng_ack    = 1'b1;
    egress_rdy = 1'b1;
    repeat (3) step();

    // Long stall without ack.
    idle_inputs();
    ingress_vld = 1'b1;
    ingress_cmd = 64'h3333;
    step();
    ingress_vld = 1'b0;
    repeat (1000) step();
    eng_ack    = 1'b1;
    egress_rdy = 1'b1;
    repeat (3) step();

    // Reset while issuing with two entries queued.
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      ingress_vld = 1'b1;
      ingress_cmd = 64'(16'hC000 + i);
      step();
    end
    ingress_vld = 1'b0;
    chk("pre_rst_queued", 64'(fifo_cnt), 64'd2);
    do_reset();
    repeat (5) step();

    // Spurious acks while waiting and while status is pending.
    eng_ack = 1'b1;
    eng_err = 1'b1;
    repeat (3) step();
    eng_ack = 1'b0;
    eng_err = 1'b0;
    ingress_vld = 1'b1;
    ingress_cmd = 64'h4444;
    step();
    ingress_vld = 1'b0;
    step();
    eng_ack = 1'b1;
    step();
    eng_err = 1'b1;
    repeat (3) step();
    chk("spurious_status", 64'(egress_status), 64'd0);
    idle_inputs();
    egress_rdy = 1'b1;
    repeat (2) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ingress_vld = 1'($urandom % 2);
      ingress_cmd = {$urandom, $urandom};
      eng_ack     = ($urandom % 4) == 0;
      eng_err     = 1'($urandom % 2);
      egress_rdy  = ($urandom % 3) != 0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
